ifu: RTL
========

IFU -- requirements
Module: ifu

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000: PC loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port inst_addr  output  32  byte address to combinational instruction ROM; equals current PC.
REQ-005 SHALL have port inst_data  input  32  ROM word for inst_addr, valid in the same cycle.
REQ-006 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-007 SHALL have port redirect_pc  input  32  redirect target; bits [1:0] ignored and treated as 0.
REQ-008 SHALL have port out_valid  output  1  instruction offered to decode.
REQ-009 SHALL have port out_ready  input  1  decode accepts the instruction.
REQ-010 SHALL have port out_pc  output  32  PC of the offered instruction.
REQ-011 SHALL have port out_inst  output  32  offered instruction word.
REQ-012 SHALL have ports perf_fetch_cnt and perf_stall_cnt  output  32 each  performance counters (see Configuration).

Function
REQ-013 SHALL hold a PC register and drive inst_addr = PC combinationally.
REQ-014 SHALL treat a fetch as issued in any cycle where the skid entry is empty and redirect_valid=0; on the edge, PC <= PC+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-015 SHALL, on an issued fetch, capture {PC, inst_data} into the output stage if it is empty or being consumed (out_valid & out_ready), else into the skid entry.
REQ-016 SHALL hold out_valid, out_pc and out_inst stable while out_valid=1 and out_ready=0.
REQ-017 SHALL, on consumption with the skid entry full, move the skid entry to the output stage and free the skid entry in the same edge.
REQ-018 SHALL never drop or duplicate an instruction; out_pc values SHALL be sequential (+4) between redirects.
REQ-019 SHALL have output-stage states EMPTY (out_valid=0), ONE (out_valid=1, skid empty) and FULL (out_valid=1, skid full); FULL SHALL be left only via consumption or redirect.
REQ-020 SHALL, when redirect_valid=1, on that edge: PC <= {redirect_pc[31:2],2'b00}, clear out_valid and the skid entry, issue no fetch; redirect SHALL take priority over every other event.
REQ-021 SHALL count an instruction with out_valid & out_ready in the redirect cycle as consumed by decode.
REQ-022 SHALL have a latency of exactly 1 cycle: the first instruction at the target appears with out_valid=1 in the second cycle after the redirect cycle.
REQ-023 SHALL, with out_ready held at 1, sustain one instruction per cycle.

Reset
REQ-024 SHALL, on a rising edge with rst_n=0, set PC=RESET_PC, out_valid=0, skid empty, out_pc=0, out_inst=0, and both counters to 0, overriding redirect and handshake.
REQ-025 SHALL, when reset is asserted mid-stream, discard all buffered instructions.
REQ-026 SHALL issue the first fetch in the first cycle with rst_n=1, so out_valid=1 with out_pc=RESET_PC in the following cycle.

Configuration
REQ-027 SHALL, with macro IFU_PERF_EN defined: increment perf_fetch_cnt per issued fetch, increment perf_stall_cnt per cycle with out_valid=1 and out_ready=0, and let both wrap at 2^32.
REQ-028 SHALL, without IFU_PERF_EN, drive both counters as constant 0 and contain no counter flops.

Structure
REQ-029 SHALL take XLEN=32, INST_NOP=32'h0000_0013 and the RESET_PC default from a shared package npc_pkg, reused by the ROM and decode.
REQ-030 SHALL place the output stage plus skid entry in one sub-module, ifu_skid (parameterised width, valid/ready both sides, synchronous flush input).

Verification
REQ-031 SHALL verify reset release with out_ready=1: out_pc sequence 8000_0000, 8000_0004, 8000_0008 on consecutive cycles, with out_inst matching the ROM words.
REQ-032 SHALL verify backpressure: out_ready=0 for 3 cycles at out_pc=8000_0004 -> output held stable, FULL reached, PC stops at 8000_000C, perf_stall_cnt=3 (IFU_PERF_EN), and after release 8000_0008 follows with no gap.
REQ-033 SHALL verify redirect: redirect_pc=8000_0102 while FULL -> next cycle out_valid=0, then out_pc=8000_0100, and the skid entry is never emitted.
REQ-034 SHALL verify wrap: redirect to FFFF_FFFC -> out_pc FFFF_FFFC then 0000_0000.
REQ-035 SHALL verify mid-stream reset: rst_n=0 for 1 cycle while FULL -> out_valid=0, and out_pc=RESET_PC is the first instruction after release.

Source files
------------

// File: rtl/npc_pkg.sv
// Shared definitions for the fetch path, ROM and decode.
//   XLEN             : datapath width
//   INST_NOP         : canonical no-op instruction word (addi x0, x0, 0)
//   RESET_PC_DEFAULT : default boot address
//   skid_state_e     : occupancy of the fetch output stage plus skid entry
//   fetch_pkt_t      : {pc, inst} pair carried from fetch to decode
package npc_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

    // StEmpty: nothing offered; StOne: output stage only; StFull: output + skid.
    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StFull
    } skid_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_pkt_t;

    // Instructions are word aligned; low address bits are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_skid.sv
// Output register plus a single skid entry between fetch and decode.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   flush               : synchronous discard of everything buffered
//   in_valid/in_ready   : upstream handshake; in_ready drops only when the skid is full
//   in_data             : payload captured on an accepted push
//   out_valid/out_ready : downstream handshake
//   out_data            : registered payload offered downstream
module ifu_skid
    import npc_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    skid_state_e      state_q, state_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             push;
    logic             consume;

    assign in_ready  = (state_q != StFull);
    assign out_valid = (state_q != StEmpty);
    assign out_data  = out_data_q;
    assign push      = in_valid & in_ready;
    assign consume   = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            // Payload registers keep stale data; only occupancy is cleared.
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (push) begin
                        out_data_d = in_data;
                        state_d    = StOne;
                    end
                end
                StOne: begin
                    if (push) begin
                        if (consume) begin
                            out_data_d = in_data;
                        end else begin
                            skid_data_d = in_data;
                            state_d     = StFull;
                        end
                    end else if (consume) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    // No push is possible here, so the skid simply drains forward.
                    if (consume) begin
                        out_data_d = skid_data_q;
                        state_d    = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StEmpty;
            out_data_q  <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            skid_data_q <= skid_data_d;
        end
    end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: PC register, combinational ROM access and a
// two-deep output buffer towards decode.
// Build option: define IFU_PERF_EN to enable the fetch/stall counters;
// otherwise both counter outputs are tied to 0.
// Ports:
//   clk, rst_n                  : clock, synchronous active-low reset
//   inst_addr / inst_data       : ROM address (current PC) and same-cycle word
//   redirect_valid, redirect_pc : branch/jump redirect, highest priority
//   out_valid/out_ready         : handshake to decode
//   out_pc, out_inst            : offered instruction and its PC
//   perf_fetch_cnt              : issued fetches
//   perf_stall_cnt              : cycles with out_valid & !out_ready
module ifu
    import npc_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] inst_addr,
    input  logic [XLEN-1:0] inst_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_inst,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_stall_cnt
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            fetch_req;
    logic            fetch_ready;
    logic            fetch;
    fetch_pkt_t      fetch_pkt;
    fetch_pkt_t      out_pkt;

    // A fetch issues whenever the skid has room and no redirect is pending.
    assign fetch_req = ~redirect_valid;
    assign fetch     = fetch_req & fetch_ready;
    assign inst_addr = pc_q;

    assign fetch_pkt.pc   = pc_q;
    assign fetch_pkt.inst = inst_data;

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = align_pc(redirect_pc);
        end else if (fetch) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    ifu_skid #(
        .WIDTH($bits(fetch_pkt_t))
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redirect_valid),
        .in_valid (fetch_req),
        .in_ready (fetch_ready),
        .in_data  (fetch_pkt),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_pkt)
    );

    assign out_pc   = out_pkt.pc;
    assign out_inst = out_pkt.inst;

`ifdef IFU_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (fetch) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (out_valid && !out_ready) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`else
    assign perf_fetch_cnt = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule
